// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory-bus arbiter: bus commands,
// tag-owner table entries and the client-id width helper.
package mem_bus_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int NUM_TAGS    = 15;
  localparam int MAX_CID_W   = 3;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_CID_W-1:0] cid;
  } owner_entry_t;

  function automatic int cid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between cache clients, the arbiter and the tagged memory port.
// master = client/memory environment, slave = arbiter.
interface mem_bus_arbiter_if #(
  parameter int NUM_CLIENTS = 2
);
  import mem_bus_arbiter_pkg::*;

  logic [NUM_CLIENTS-1:0][1:0]      cl2arb_command;
  logic [NUM_CLIENTS-1:0][XLEN-1:0] cl2arb_addr;
  logic [NUM_CLIENTS-1:0][63:0]     cl2arb_data;
  logic [NUM_CLIENTS-1:0][3:0]      arb2cl_response;
  logic [63:0]                      arb2cl_data;
  logic [NUM_CLIENTS-1:0][3:0]      arb2cl_tag;
  logic [3:0]                       mem2proc_response;
  logic [63:0]                      mem2proc_data;
  logic [3:0]                       mem2proc_tag;
  logic [1:0]                       proc2mem_command;
  logic [XLEN-1:0]                  proc2mem_addr;
  logic [63:0]                      proc2mem_data;
  logic                             proto_err;

  modport master (
    output cl2arb_command, cl2arb_addr, cl2arb_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  arb2cl_response, arb2cl_data, arb2cl_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proto_err
  );

  modport slave (
    input  cl2arb_command, cl2arb_addr, cl2arb_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output arb2cl_response, arb2cl_data, arb2cl_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proto_err
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_select.sv
// Masked priority encoder: first request at or above start, wrapping to the
// lowest request when none lies above. start = 0 gives plain fixed priority.
module mem_bus_arbiter_rr_select #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_cid
);

  logic         lo_found_s;
  logic         hi_found_s;
  logic [W-1:0] lo_cid_s;
  logic [W-1:0] hi_cid_s;

  // lo_* tracks the first request overall, hi_* the first one at or after start
  always_comb begin
    lo_found_s = 1'b0;
    hi_found_s = 1'b0;
    lo_cid_s   = '0;
    hi_cid_s   = '0;
    for (int i = 0; i < N; i++) begin
      lo_cid_s   = (req[i] && !lo_found_s) ? W'(i) : lo_cid_s;
      lo_found_s = lo_found_s | req[i];
      hi_cid_s   = (req[i] && (i >= int'(start)) && !hi_found_s) ? W'(i) : hi_cid_s;
      hi_found_s = hi_found_s | (req[i] && (i >= int'(start)));
    end
  end

  assign gnt_valid = lo_found_s;
  assign gnt_cid   = hi_found_s ? hi_cid_s : lo_cid_s;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Multiplexes NUM_CLIENTS cache requesters onto one tagged memory port and
// routes accept tags and load returns back to the issuing client.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter bit RR_MODE     = 1'b0
) (
  input logic              clock,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int CID_W = cid_width(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0]  elig_s;
  logic [CID_W-1:0]        start_s;
  logic                    gnt_valid_s;
  logic [CID_W-1:0]        gnt_cid_s;
  logic [1:0]              mux_cmd_s;
  logic [XLEN-1:0]         mux_addr_s;
  logic [63:0]             mux_data_s;
  logic                    accept_s;
  logic                    alloc_s;
  logic                    ret_hit_s;
  logic                    ret_miss_s;
  logic                    alloc_clash_s;
  owner_entry_t            ret_entry_s;

  logic                    pend_valid_q, pend_valid_d;
  logic [CID_W-1:0]        pend_cid_q, pend_cid_d;
  logic                    pend_is_load_q, pend_is_load_d;
  logic [CID_W-1:0]        rr_ptr_q, rr_ptr_d;
  owner_entry_t [NUM_TAGS:0] owner_q, owner_d;
  logic                    proto_err_q, proto_err_d;

  // The client granted last cycle is blacked out while it receives its response
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      elig_s[i] = (bus.cl2arb_command[i] != BUS_NONE) &&
                  !(pend_valid_q && (pend_cid_q == CID_W'(i)));
    end
  end

  assign start_s = RR_MODE ? rr_ptr_q : '0;

  mem_bus_arbiter_rr_select #(
    .N (NUM_CLIENTS),
    .W (CID_W)
  ) u_rr_select (
    .req       (elig_s),
    .start     (start_s),
    .gnt_valid (gnt_valid_s),
    .gnt_cid   (gnt_cid_s)
  );

  // Granted client's request onto the memory side
  always_comb begin
    mux_cmd_s  = '0;
    mux_addr_s = '0;
    mux_data_s = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      mux_cmd_s  = (gnt_valid_s && (gnt_cid_s == CID_W'(i))) ? bus.cl2arb_command[i] : mux_cmd_s;
      mux_addr_s = (gnt_valid_s && (gnt_cid_s == CID_W'(i))) ? bus.cl2arb_addr[i]    : mux_addr_s;
      mux_data_s = (gnt_valid_s && (gnt_cid_s == CID_W'(i))) ? bus.cl2arb_data[i]    : mux_data_s;
    end
  end

  assign bus.proc2mem_command = reset ? 2'b00 : mux_cmd_s;
  assign bus.proc2mem_addr    = reset ? '0 : mux_addr_s;
  assign bus.proc2mem_data    = reset ? 64'd0 : mux_data_s;

  assign accept_s    = pend_valid_q && (bus.mem2proc_response != 4'd0);
  assign alloc_s     = accept_s && pend_is_load_q;
  assign ret_entry_s = owner_q[bus.mem2proc_tag];
  assign ret_hit_s   = (bus.mem2proc_tag != 4'd0) && ret_entry_s.valid;
  assign ret_miss_s  = (bus.mem2proc_tag != 4'd0) && !ret_entry_s.valid;
  // A same-cycle return of the allocated tag frees it first, so that is not a clash
  assign alloc_clash_s = alloc_s && owner_q[bus.mem2proc_response].valid &&
                         !(ret_hit_s && (bus.mem2proc_tag == bus.mem2proc_response));

  // Accept-tag and return-tag routing to the owning client only
  always_comb begin
    bus.arb2cl_response = '0;
    bus.arb2cl_tag      = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      bus.arb2cl_response[i] = (pend_valid_q && (pend_cid_q == CID_W'(i))) ?
                               bus.mem2proc_response : 4'd0;
      bus.arb2cl_tag[i]      = (ret_hit_s && (ret_entry_s.cid == MAX_CID_W'(i))) ?
                               bus.mem2proc_tag : 4'd0;
    end
  end

  assign bus.arb2cl_data = bus.mem2proc_data;
  assign bus.proto_err   = proto_err_q;

  // Next-state: pending grant, round-robin pointer, owner table, error flag
  always_comb begin
    pend_valid_d   = gnt_valid_s;
    pend_cid_d     = gnt_cid_s;
    pend_is_load_d = gnt_valid_s && (mux_cmd_s == BUS_LOAD);
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    proto_err_d    = proto_err_q | ret_miss_s | alloc_clash_s;
    if (accept_s) begin
      rr_ptr_d = (pend_cid_q == CID_W'(NUM_CLIENTS - 1)) ? '0 : pend_cid_q + CID_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    owner_d[0] = '0;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      owner_d[t] = (alloc_s && (bus.mem2proc_response == 4'(t))) ?
                   owner_entry_t'{valid: 1'b1, cid: MAX_CID_W'(pend_cid_q)} :
                   ((ret_hit_s && (bus.mem2proc_tag == 4'(t))) ? owner_entry_t'('0) : owner_q[t]);
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_valid_q   <= 1'b0;
      pend_cid_q     <= '0;
      pend_is_load_q <= 1'b0;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_cid_q     <= pend_cid_d;
      pend_is_load_q <= pend_is_load_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      proto_err_q    <= proto_err_d;
    end
  end

endmodule
